// File: rtl/hsi_pkg.sv
// Shared types and constants for the HSI pixel scheduler and its result FIFO.
package hsi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

  localparam logic [1:0] OP_DOT   = 2'b00;
  localparam logic [1:0] OP_CROSS = 2'b01;

  localparam int RES_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] idx;
    logic [RES_W_DEF-1:0] result;
  } sched_entry_t;

endpackage

// File: rtl/hsi_result_fifo.sv
// Synchronous result FIFO with flush. A push is accepted when full if a pop frees a slot.
module hsi_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_LVL = (AW+1)'(0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_LVL);
  assign empty     = (count_r == ZERO_LVL);
  assign level     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || pop);

  // Storage, pointers and occupancy; flush only resets the bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= ZERO_LVL;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= ZERO_LVL;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/hsi_pixel_scheduler.sv
// Drives hsi_vector_core one pixel at a time and queues index-tagged results for a
// valid/ready consumer, with abort, per-pixel timeout and completion pulse.
module hsi_pixel_scheduler
  import hsi_pkg::*;
#(
  parameter int RES_W       = RES_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 4096,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_start_i,
  input  logic             cfg_abort_i,
  input  logic [CNT_W-1:0] cfg_num_pixels_i,
  input  logic [1:0]       cfg_op_code_i,
  input  logic [15:0]      cfg_pixel_size_i,
  output logic             core_start_o,
  output logic [1:0]       core_op_code_o,
  output logic [15:0]      core_pixel_size_o,
  input  logic [RES_W-1:0] core_result_i,
  input  logic             core_valid_result_i,
  input  logic             core_pixel_done_i,
  input  logic             core_busy_i,
  output logic             res_valid_o,
  output logic [RES_W-1:0] res_data_o,
  output logic [CNT_W-1:0] res_idx_o,
  input  logic             res_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [CNT_W-1:0] pixels_done_o,
  output logic [LVL_W-1:0] fifo_level_o
);

  localparam int EW    = CNT_W + RES_W;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  sched_state_t     state_r;
  logic [CNT_W-1:0] num_r;
  logic [CNT_W-1:0] idx_r;
  logic [1:0]       op_r;
  logic [15:0]      size_r;
  logic             done_r;
  logic             error_r;
  logic [TMO_W-1:0] tmo_r;

  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             push_s;
  logic             pop_s;
  logic             last_s;
  logic [EW-1:0]    fifo_head_s;
  logic             unused_busy_s;

  // Core busy is informational; the handshake relies on pixel_done alone.
  assign unused_busy_s = core_busy_i;

  assign core_start_o      = (state_r == ISSUE) && !fifo_full_s && !cfg_abort_i;
  assign push_s            = (state_r == WAIT) && core_pixel_done_i && !cfg_abort_i;
  assign pop_s             = !fifo_empty_s && res_ready_i;
  assign last_s            = (idx_r == (num_r - CNT_W'(1)));
  assign core_op_code_o    = op_r;
  assign core_pixel_size_o = size_r;
  assign busy_o            = (state_r != IDLE);
  assign done_o            = done_r;
  assign error_o           = error_r;
  assign pixels_done_o     = idx_r;
  assign res_valid_o       = !fifo_empty_s;
  assign res_idx_o         = fifo_head_s[EW-1:RES_W];
  assign res_data_o        = fifo_head_s[RES_W-1:0];

  hsi_result_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush   (cfg_abort_i),
    .push    (push_s),
    .wr_data ({idx_r, core_result_i}),
    .pop     (pop_s),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level_o)
  );

  // Run sequencer: IDLE -> ISSUE -> WAIT per pixel, abort always returns to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      num_r   <= {CNT_W{1'b0}};
      idx_r   <= {CNT_W{1'b0}};
      op_r    <= 2'b00;
      size_r  <= 16'h0000;
      done_r  <= 1'b0;
      error_r <= 1'b0;
      tmo_r   <= {TMO_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cfg_abort_i) begin
            state_r <= IDLE;
          end else if (cfg_start_i && (cfg_num_pixels_i == {CNT_W{1'b0}})) begin
            done_r <= 1'b1;
          end else if (cfg_start_i) begin
            num_r   <= cfg_num_pixels_i;
            op_r    <= cfg_op_code_i;
            size_r  <= cfg_pixel_size_i;
            idx_r   <= {CNT_W{1'b0}};
            error_r <= 1'b0;
            state_r <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (cfg_abort_i) begin
            state_r <= IDLE;
          end else if (!fifo_full_s) begin
            tmo_r   <= {TMO_W{1'b0}};
            state_r <= WAIT;
          end else begin
            state_r <= ISSUE;
          end
        end
        WAIT: begin
          if (cfg_abort_i) begin
            state_r <= IDLE;
          end else if (core_pixel_done_i) begin
            idx_r <= idx_r + CNT_W'(1);
            if (!core_valid_result_i) error_r <= 1'b1;
            if (last_s) begin
              done_r  <= 1'b1;
              state_r <= IDLE;
            end else begin
              state_r <= ISSUE;
            end
          end else if ((TIMEOUT_CYC != 0) && (tmo_r == TMO_LAST)) begin
            error_r <= 1'b1;
            state_r <= IDLE;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hsi_pixel_scheduler.sv
// Directed bench for hsi_pixel_scheduler with a behavioural core answering 3 cycles after each start.
module tb_hsi_pixel_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_start_i = 1'b0;
  logic        cfg_abort_i = 1'b0;
  logic [15:0] cfg_num_pixels_i = 16'd0;
  logic [1:0]  cfg_op_code_i = 2'b00;
  logic [15:0] cfg_pixel_size_i = 16'd0;
  logic        core_start_o;
  logic [1:0]  core_op_code_o;
  logic [15:0] core_pixel_size_o;
  logic [15:0] core_result_i = 16'd0;
  logic        core_valid_result_i = 1'b0;
  logic        core_pixel_done_i = 1'b0;
  logic        core_busy_i = 1'b0;
  logic        res_valid_o;
  logic [15:0] res_data_o;
  logic [15:0] res_idx_o;
  logic        res_ready_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] pixels_done_o;
  logic [1:0]  fifo_level_o;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  int res_k     = 0;
  int wait_cnt  = 0;
  bit core_answer = 1'b1;
  bit core_valid_mode = 1'b1;
  logic [31:0] pop_q [$];
  int s0, d0, q0;

  hsi_pixel_scheduler #(
    .RES_W       (16),
    .CNT_W       (16),
    .FIFO_DEPTH  (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .cfg_start_i         (cfg_start_i),
    .cfg_abort_i         (cfg_abort_i),
    .cfg_num_pixels_i    (cfg_num_pixels_i),
    .cfg_op_code_i       (cfg_op_code_i),
    .cfg_pixel_size_i    (cfg_pixel_size_i),
    .core_start_o        (core_start_o),
    .core_op_code_o      (core_op_code_o),
    .core_pixel_size_o   (core_pixel_size_o),
    .core_result_i       (core_result_i),
    .core_valid_result_i (core_valid_result_i),
    .core_pixel_done_i   (core_pixel_done_i),
    .core_busy_i         (core_busy_i),
    .res_valid_o         (res_valid_o),
    .res_data_o          (res_data_o),
    .res_idx_o           (res_idx_o),
    .res_ready_i         (res_ready_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .error_o             (error_o),
    .pixels_done_o       (pixels_done_o),
    .fifo_level_o        (fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  // Core model and monitors run on the falling edge, away from the DUT's sampling edge.
  always @(negedge clk_i) begin
    core_pixel_done_i   = 1'b0;
    core_valid_result_i = 1'b0;
    if (wait_cnt > 0) begin
      wait_cnt = wait_cnt - 1;
      if (wait_cnt == 0) begin
        core_pixel_done_i   = 1'b1;
        core_valid_result_i = core_valid_mode;
        core_result_i       = 16'(17 * (res_k + 1));
        res_k               = res_k + 1;
      end
    end
    core_busy_i = (wait_cnt > 0);
    if (core_start_o) begin
      start_cnt = start_cnt + 1;
      if (core_answer) wait_cnt = 3;
    end
    if (done_o) done_cnt = done_cnt + 1;
    if (res_valid_o && res_ready_i) pop_q.push_back({res_idx_o, res_data_o});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic launch(input logic [15:0] num, input logic [1:0] op, input logic [15:0] size);
    tick(1);
    cfg_num_pixels_i = num;
    cfg_op_code_i    = op;
    cfg_pixel_size_i = size;
    cfg_start_i      = 1'b1;
    tick(1);
    cfg_start_i = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag, input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(busy_o), 32'd0);
  endtask

  task automatic mark;
    s0 = start_cnt; d0 = done_cnt; q0 = pop_q.size(); res_k = 0;
  endtask

  task automatic abort_pulse;
    cfg_abort_i = 1'b1;
    tick(1);
    cfg_abort_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(3);
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_start", 32'(core_start_o), 32'd0);
    check("rst_flags", {29'd0, done_o, error_o, res_valid_o}, 32'd0);
    check("rst_level", 32'(fifo_level_o), 32'd0);
    check("rst_cfg",   {14'd0, core_op_code_o, core_pixel_size_o}, 32'd0);
    rst_i = 1'b0;
    tick(2);

    // Four pixels, consumer always ready.
    mark(); res_ready_i = 1'b1;
    launch(16'd4, 2'b00, 16'd32);
    check("t1_first_start", 32'(core_start_o), 32'd1);
    wait_not_busy("t1_finish", 200);
    tick(3);
    check("t1_starts", 32'(start_cnt - s0), 32'd4);
    check("t1_done",   32'(done_cnt - d0), 32'd1);
    check("t1_pixels", 32'(pixels_done_o), 32'd4);
    check("t1_npop",   32'(pop_q.size() - q0), 32'd4);
    check("t1_r0", pop_q[q0+0], 32'h0000_0011);
    check("t1_r1", pop_q[q0+1], 32'h0001_0022);
    check("t1_r2", pop_q[q0+2], 32'h0002_0033);
    check("t1_r3", pop_q[q0+3], 32'h0003_0044);
    check("t1_cfg", {14'd0, core_op_code_o, core_pixel_size_o}, 32'h0000_0020);

    // Backpressure: depth-2 FIFO stalls after two pixels until the consumer drains it.
    mark(); res_ready_i = 1'b0;
    launch(16'd5, 2'b01, 16'd64);
    tick(30);
    check("t2_stall_starts", 32'(start_cnt - s0), 32'd2);
    check("t2_stall_level",  32'(fifo_level_o), 32'd2);
    check("t2_stall_busy",   32'(busy_o), 32'd1);
    res_ready_i = 1'b1;
    wait_not_busy("t2_finish", 200);
    tick(3);
    check("t2_starts", 32'(start_cnt - s0), 32'd5);
    check("t2_done",   32'(done_cnt - d0), 32'd1);
    check("t2_npop",   32'(pop_q.size() - q0), 32'd5);
    check("t2_r0", pop_q[q0+0], 32'h0000_0011);
    check("t2_r2", pop_q[q0+2], 32'h0002_0033);
    check("t2_r4", pop_q[q0+4], 32'h0004_0055);
    check("t2_cfg", {14'd0, core_op_code_o, core_pixel_size_o}, 32'h0001_0040);

    // Zero-pixel launch only pulses done.
    mark();
    launch(16'd0, 2'b00, 16'd8);
    check("t3_done_now", 32'(done_o), 32'd1);
    check("t3_busy", 32'(busy_o), 32'd0);
    tick(5);
    check("t3_starts", 32'(start_cnt - s0), 32'd0);
    check("t3_done",   32'(done_cnt - d0), 32'd1);

    // Abort during WAIT of pixel 3.
    mark();
    launch(16'd10, 2'b00, 16'd16);
    for (int n = 0; n < 200 && (start_cnt - s0) < 4; n++) tick(1);
    check("t4_reached_p3", 32'(start_cnt - s0), 32'd4);
    abort_pulse();
    check("t4_busy",   32'(busy_o), 32'd0);
    check("t4_level",  32'(fifo_level_o), 32'd0);
    check("t4_pixels", 32'(pixels_done_o), 32'd3);
    tick(20);
    check("t4_starts", 32'(start_cnt - s0), 32'd4);
    check("t4_done",   32'(done_cnt - d0), 32'd0);

    // Abort while stalled on a full FIFO flushes it.
    mark(); res_ready_i = 1'b0;
    launch(16'd5, 2'b00, 16'd8);
    tick(30);
    check("t4b_level_pre", 32'(fifo_level_o), 32'd2);
    abort_pulse();
    check("t4b_level", 32'(fifo_level_o), 32'd0);
    check("t4b_state", {30'd0, busy_o, res_valid_o}, 32'd0);
    tick(10);
    check("t4b_starts", 32'(start_cnt - s0), 32'd2);

    // Abort in IDLE flushes a leftover result.
    mark();
    launch(16'd1, 2'b00, 16'd16);
    wait_not_busy("t4c_finish", 100);
    tick(2);
    check("t4c_level_pre", 32'(fifo_level_o), 32'd1);
    abort_pulse();
    check("t4c_level", 32'(fifo_level_o), 32'd0);
    res_ready_i = 1'b1;

    // Timeout: core never answers.
    mark(); core_answer = 1'b0;
    launch(16'd2, 2'b00, 16'd16);
    tick(16);
    check("t5_err_early", {30'd0, busy_o, error_o}, 32'd2);
    tick(1);
    check("t5_err_set", {30'd0, busy_o, error_o}, 32'd1);
    tick(5);
    check("t5_starts", 32'(start_cnt - s0), 32'd1);
    check("t5_nodone", 32'(done_cnt - d0), 32'd0);
    core_answer = 1'b1;
    mark();
    launch(16'd1, 2'b00, 16'd16);
    check("t5_err_clear", 32'(error_o), 32'd0);
    wait_not_busy("t5_finish", 100);
    tick(1);
    check("t5_done", 32'(done_cnt - d0), 32'd1);

    // Done without valid still pushes but flags an error.
    mark(); core_valid_mode = 1'b0;
    launch(16'd1, 2'b00, 16'd16);
    wait_not_busy("t5b_finish", 100);
    tick(3);
    core_valid_mode = 1'b1;
    check("t5b_error", 32'(error_o), 32'd1);
    check("t5b_npop",  32'(pop_q.size() - q0), 32'd1);

    // Start while busy is ignored.
    mark();
    launch(16'd3, 2'b00, 16'd20);
    tick(2);
    cfg_op_code_i = 2'b01; cfg_pixel_size_i = 16'd99; cfg_num_pixels_i = 16'd7;
    cfg_start_i = 1'b1;
    tick(1);
    cfg_start_i = 1'b0;
    check("t6_cfg_mid", {13'd0, busy_o, core_op_code_o, core_pixel_size_o}, 32'h0004_0014);
    wait_not_busy("t6_finish", 200);
    tick(3);
    check("t6_starts", 32'(start_cnt - s0), 32'd3);
    check("t6_done",   32'(done_cnt - d0), 32'd1);
    check("t6_pixels", 32'(pixels_done_o), 32'd3);

    // Start together with abort in IDLE is dropped.
    mark();
    cfg_num_pixels_i = 16'd4; cfg_op_code_i = 2'b01;
    cfg_start_i = 1'b1; cfg_abort_i = 1'b1;
    tick(1);
    cfg_start_i = 1'b0; cfg_abort_i = 1'b0;
    check("t6b_busy", 32'(busy_o), 32'd0);
    tick(10);
    check("t6b_starts", 32'(start_cnt - s0), 32'd0);
    check("t6b_done",   32'(done_cnt - d0), 32'd0);
    check("t6b_op",     32'(core_op_code_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hsi_pixel_scheduler.md
Name: hsi_pixel_scheduler

Overview:
- Sequences hsi_vector_core over a block of N pixels: one core start pulse per pixel, waits for the pixel to complete, then captures the result.
- Each result is tagged with its pixel index and buffered in a small FIFO that a downstream consumer drains with a valid/ready handshake.
- Sits between the configuration registers / DMA and the vector core.
- Provides backpressure, abort, a per-pixel timeout and completion signalling.

Parameters:
- RES_W, 16: core result width.
- CNT_W, 16: pixel counter and index width.
- FIFO_DEPTH, 8: result FIFO entries; must be a power of 2 and at least 2.
- TIMEOUT_CYC, 4096: maximum cycles to wait for core_pixel_done_i per pixel; 0 disables the timeout.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- cfg_start_i  in  1  launch pulse; honoured only in IDLE.
- cfg_abort_i  in  1  abort request; level, sampled every cycle.
- cfg_num_pixels_i  in  CNT_W  number of pixels to process.
- cfg_op_code_i  in  2  operation code: 00 dot, 01 cross.
- cfg_pixel_size_i  in  16  vector length per pixel.
- core_start_o  out  1  one-cycle start pulse to the core.
- core_op_code_o  out  2  latched operation code.
- core_pixel_size_o  out  16  latched vector length.
- core_result_i  in  RES_W  core result.
- core_valid_result_i  in  1  core result valid.
- core_pixel_done_i  in  1  core finished the current pixel.
- core_busy_i  in  1  core busy; status only.
- res_valid_o  out  1  FIFO not empty.
- res_data_o  out  RES_W  FIFO head result.
- res_idx_o  out  CNT_W  pixel index of the FIFO head.
- res_ready_i  in  1  consumer pops the head when res_valid_o is high.
- busy_o  out  1  FSM not in IDLE.
- done_o  out  1  one-cycle pulse after the last pixel's result is pushed.
- error_o  out  1  sticky timeout or missing-valid flag.
- pixels_done_o  out  CNT_W  results pushed in the current run.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, configuration latches cleared.
- IDLE:
  - cfg_start_i with num>0: latch num, op_code and pixel_size; clear idx, pixels_done_o and error_o; go to ISSUE.
  - cfg_start_i with num==0: done_o pulses on the next cycle; FSM stays in IDLE.
- ISSUE, FIFO not full: core_start_o=1 for this single cycle; go to WAIT next cycle.
- ISSUE, FIFO full: core_start_o=0; hold (stall).
- First-pixel latency: core_start_o is high in the cycle after cfg_start_i is sampled, provided the FIFO is not full.
- WAIT, on entry: clear the timeout counter.
- WAIT, core_pixel_done_i=1:
  - Push {idx, core_result_i} into the FIFO.
  - If core_valid_result_i=0 in the same cycle, still push and set error_o.
  - Increment idx and pixels_done_o.
  - If idx==num-1, go to IDLE and pulse done_o in the following cycle; otherwise go to ISSUE.
- WAIT, timeout: if TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 without core_pixel_done_i, set error_o and go to IDLE. No push, no done_o.
- core_pixel_done_i outside WAIT is ignored.
- Minimum pixel period: 2 cycles (ISSUE, then WAIT with an immediate done).
- Overflow: the FIFO cannot overflow. ISSUE requires a free slot, and only pops occur between ISSUE and the push.
- Pop: the FIFO pops when res_valid_o && res_ready_i. Push and pop in the same cycle are allowed, including when full (pop frees) and when empty (fall-through is not required; data appears the next cycle).
- Abort (cfg_abort_i=1):
  - In any non-IDLE state: next state IDLE, FIFO flushed, core_start_o forced to 0 that cycle, no done_o, error_o unchanged.
  - In IDLE: flushes the FIFO.
  - Abort together with start in IDLE: abort wins and the start is dropped.
- cfg_start_i while busy_o=1 is ignored and has no side effects.
- core_op_code_o and core_pixel_size_o are stable from launch to the end of the run and hold their last value in IDLE.
- Counters: idx and pixels_done_o use CNT_W bits; num ≤ 2^CNT_W-1, so no wrap occurs within a run.
- error_o clears only on an accepted cfg_start_i or on reset.
- Reset mid-operation: immediate return to reset values. An in-flight core operation is not tracked.

Decomposition:
- hsi_pkg holds:
  - sched_state_t enum {IDLE, ISSUE, WAIT}
  - OP_DOT=2'b00, OP_CROSS=2'b01
  - RES_W_DEF, CNT_W_DEF
  - sched_entry_t struct {idx, result}
- Sub-module hsi_result_fifo: synchronous FIFO with parameterised width and depth, ports push, pop, flush, full, empty and level.

Test Plan:
- num=4, pixel_size=32, op=00, res_ready_i=1, core answers done with results 0x11/0x22/0x33/0x44 after 3 cycles → four core_start_o pulses; FIFO outputs (0,0x11),(1,0x22),(2,0x33),(3,0x44); done_o pulses once; pixels_done_o=4.
- FIFO_DEPTH=2, num=5, res_ready_i=0 → exactly 2 core_start_o pulses and fifo_level_o=2. Assert res_ready_i → the remaining 3 pixels complete, all 5 results arrive in index order, done_o pulses.
- num=0 with cfg_start_i → no core_start_o; done_o pulses the next cycle; busy_o stays 0.
- num=10, cfg_abort_i during WAIT of pixel 3 → IDLE next cycle, fifo_level_o=0, no further core_start_o, no done_o.
- TIMEOUT_CYC=16, core never asserts done → error_o=1 after 16 WAIT cycles; FSM returns to IDLE; the next cfg_start_i clears error_o.
- cfg_start_i pulsed mid-run with different op_code → ignored; core_op_code_o unchanged. cfg_start_i and cfg_abort_i in the same IDLE cycle → no launch.
